// File: rtl/clarvi_lsu.sv
// Load/store unit for the RV64 pipeline: turns one ALU-addressed load or store into a
// single Avalon-MM access on a 64-bit bus and returns exactly one response per request.
module clarvi_lsu #(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_is_store,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [63:0]           req_addr,
   input  logic [63:0]           req_store_data,
   input  logic [4:0]            req_rd,
   output logic                  resp_valid,
   output logic [63:0]           resp_data,
   output logic [4:0]            resp_rd,
   output logic                  resp_misaligned,
   output logic                  resp_bus_error,
   output logic [ADDR_WIDTH-1:0] main_address,
   output logic                  main_read,
   output logic                  main_write,
   output logic [7:0]            main_byteenable,
   output logic [63:0]           main_writedata,
   input  logic                  main_waitrequest,
   input  logic [63:0]           main_readdata,
   input  logic                  main_readdatavalid
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, RESP} state_t;

   localparam int CW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   state_t state, state_d;
   logic [CW-1:0] count, count_d;

   // Request fields kept for the whole access
   logic [2:0] addr_lo, addr_lo_d;
   logic [1:0] size_q, size_d;
   logic       unsigned_q, unsigned_d;
   logic       store_q, store_d;
   logic [4:0] rd_q, rd_d;

   logic                  req_ready_d, resp_valid_d, resp_misaligned_d, resp_bus_error_d;
   logic [63:0]           resp_data_d, main_writedata_d, lane;
   logic [4:0]            resp_rd_d;
   logic [ADDR_WIDTH-1:0] main_address_d;
   logic                  main_read_d, main_write_d;
   logic [7:0]            main_byteenable_d, be_base;
   logic                  misaligned, timeout;

   // Address bits above the bus width carry no information for this bus
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr[63:ADDR_WIDTH];

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d           = state;
      count_d           = count;
      addr_lo_d         = addr_lo;
      size_d            = size_q;
      unsigned_d        = unsigned_q;
      store_d           = store_q;
      rd_d              = rd_q;
      resp_valid_d      = 1'b0;
      resp_data_d       = 64'd0;
      resp_rd_d         = 5'd0;
      resp_misaligned_d = 1'b0;
      resp_bus_error_d  = 1'b0;
      main_address_d    = main_address;
      main_read_d       = main_read;
      main_write_d      = main_write;
      main_byteenable_d = main_byteenable;
      main_writedata_d  = main_writedata;
      lane              = main_readdata >> {addr_lo, 3'b000};
      timeout           = (TIMEOUT_CYCLES != 0) && (count == CW'(LIMIT));

      case (req_size)
         2'd0:    begin be_base = 8'h01; misaligned = 1'b0;           end
         2'd1:    begin be_base = 8'h03; misaligned = req_addr[0];    end
         2'd2:    begin be_base = 8'h0F; misaligned = |req_addr[1:0]; end
         default: begin be_base = 8'hFF; misaligned = |req_addr[2:0]; end
      endcase

      case (state)
         IDLE: begin
            if (req_valid) begin
               count_d    = '0;
               addr_lo_d  = req_addr[2:0];
               size_d     = req_size;
               unsigned_d = req_unsigned;
               store_d    = req_is_store;
               rd_d       = req_rd;
               if (misaligned) begin
                  state_d           = RESP;
                  resp_valid_d      = 1'b1;
                  resp_misaligned_d = 1'b1;
                  resp_rd_d         = req_rd;
               end else begin
                  state_d           = ISSUE;
                  main_read_d       = !req_is_store;
                  main_write_d      = req_is_store;
                  main_address_d    = {req_addr[ADDR_WIDTH-1:3], 3'b000};
                  main_byteenable_d = be_base << req_addr[2:0];
                  main_writedata_d  = req_store_data << {req_addr[2:0], 3'b000};
               end
            end
         end
         ISSUE: begin
            count_d = count + 1'b1;
            // A completing handshake takes priority over a watchdog expiry in the same cycle
            if (!main_waitrequest) begin
               main_read_d  = 1'b0;
               main_write_d = 1'b0;
               if (store_q) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_rd_d    = rd_q;
               end else begin
                  state_d = WAIT_DATA;
               end
            end else if (timeout) begin
               main_read_d      = 1'b0;
               main_write_d     = 1'b0;
               state_d          = RESP;
               resp_valid_d     = 1'b1;
               resp_bus_error_d = 1'b1;
               resp_rd_d        = rd_q;
            end
         end
         WAIT_DATA: begin
            count_d = count + 1'b1;
            if (main_readdatavalid) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rd_d    = rd_q;
               case (size_q)
                  2'd0:    resp_data_d = unsigned_q ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
                  2'd1:    resp_data_d = unsigned_q ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
                  2'd2:    resp_data_d = unsigned_q ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
                  default: resp_data_d = lane;
               endcase
            end else if (timeout) begin
               state_d          = RESP;
               resp_valid_d     = 1'b1;
               resp_bus_error_d = 1'b1;
               resp_rd_d        = rd_q;
            end
         end
         default: state_d = IDLE;
      endcase

      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock.
         state           <= IDLE;
         count           <= '0;
         addr_lo         <= 3'd0;
         size_q          <= 2'd0;
         unsigned_q      <= 1'b0;
         store_q         <= 1'b0;
         rd_q            <= 5'd0;
         req_ready       <= 1'b1;
         resp_valid      <= 1'b0;
         resp_data       <= 64'd0;
         resp_rd         <= 5'd0;
         resp_misaligned <= 1'b0;
         resp_bus_error  <= 1'b0;
         main_address    <= '0;
         main_read       <= 1'b0;
         main_write      <= 1'b0;
         main_byteenable <= 8'd0;
         main_writedata  <= 64'd0;
      end else begin
         state           <= state_d;
         count           <= count_d;
         addr_lo         <= addr_lo_d;
         size_q          <= size_d;
         unsigned_q      <= unsigned_d;
         store_q         <= store_d;
         rd_q            <= rd_d;
         req_ready       <= req_ready_d;
         resp_valid      <= resp_valid_d;
         resp_data       <= resp_data_d;
         resp_rd         <= resp_rd_d;
         resp_misaligned <= resp_misaligned_d;
         resp_bus_error  <= resp_bus_error_d;
         main_address    <= main_address_d;
         main_read       <= main_read_d;
         main_write      <= main_write_d;
         main_byteenable <= main_byteenable_d;
         main_writedata  <= main_writedata_d;
      end
   end

endmodule

// File: tb/tb_clarvi_lsu.sv
// Directed bench for clarvi_lsu: loads with extension, a stalled store, misalignment,
// watchdog expiry with a late readdatavalid, reset mid-access and back-to-back requests.
module tb_clarvi_lsu;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready, req_is_store, req_unsigned;
   logic [1:0]  req_size;
   logic [63:0] req_addr, req_store_data;
   logic [4:0]  req_rd;
   logic        resp_valid, resp_misaligned, resp_bus_error;
   logic [63:0] resp_data;
   logic [4:0]  resp_rd;
   logic [31:0] main_address;
   logic        main_read, main_write, main_waitrequest, main_readdatavalid;
   logic [7:0]  main_byteenable;
   logic [63:0] main_writedata, main_readdata;

   int checks   = 0;
   int failures = 0;

   clarvi_lsu #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_store_data(req_store_data), .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
      .resp_misaligned(resp_misaligned), .resp_bus_error(resp_bus_error),
      .main_address(main_address), .main_read(main_read), .main_write(main_write),
      .main_byteenable(main_byteenable), .main_writedata(main_writedata),
      .main_waitrequest(main_waitrequest), .main_readdata(main_readdata),
      .main_readdatavalid(main_readdatavalid)
   );

   always #5 clock = ~clock;

   // Advance one clock and settle just after the edge
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic set_req(input logic store, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] data, input logic [4:0] rd);
      req_valid      = 1'b1;
      req_is_store   = store;
      req_size       = size;
      req_unsigned   = uns;
      req_addr       = addr;
      req_store_data = data;
      req_rd         = rd;
   endtask

   // Zero-wait load; readdatavalid is also driven during the issue cycle, where it must be ignored
   task automatic run_load(input string tag, input logic [1:0] size, input logic uns,
                           input logic [63:0] addr, input logic [4:0] rd, input logic [63:0] rdata,
                           input logic [7:0] exp_be, input logic [63:0] exp_data);
      set_req(1'b0, size, uns, addr, 64'd0, rd);
      step();
      req_valid = 1'b0;
      check({tag, "_read"}, main_read, 1);
      check({tag, "_write"}, main_write, 0);
      check({tag, "_addr"}, main_address, addr[31:0] & 32'hFFFF_FFF8);
      check({tag, "_be"}, main_byteenable, exp_be);
      check({tag, "_ready_busy"}, req_ready, 0);
      main_readdatavalid = 1'b1;
      main_readdata      = ~rdata;
      step();
      main_readdata = rdata;
      check({tag, "_read_drop"}, main_read, 0);
      check({tag, "_no_early_resp"}, resp_valid, 0);
      step();
      main_readdatavalid = 1'b0;
      check({tag, "_resp_valid"}, resp_valid, 1);
      check({tag, "_resp_data"}, resp_data, exp_data);
      check({tag, "_resp_rd"}, resp_rd, rd);
      check({tag, "_resp_flags"}, {resp_misaligned, resp_bus_error}, 0);
      step();
      check({tag, "_resp_pulse"}, resp_valid, 0);
      check({tag, "_ready_back"}, req_ready, 1);
   endtask

   task automatic run_misaligned(input string tag, input logic [1:0] size, input logic [63:0] addr,
                                 input logic [4:0] rd);
      set_req(1'b0, size, 1'b0, addr, 64'd0, rd);
      step();
      req_valid = 1'b0;
      check({tag, "_resp_valid"}, resp_valid, 1);
      check({tag, "_misaligned"}, resp_misaligned, 1);
      check({tag, "_resp_data"}, resp_data, 0);
      check({tag, "_resp_rd"}, resp_rd, rd);
      check({tag, "_no_read"}, main_read, 0);
      step();
      check({tag, "_resp_pulse"}, resp_valid, 0);
      check({tag, "_still_no_read"}, main_read, 0);
      check({tag, "_ready"}, req_ready, 1);
   endtask

   initial begin
      reset_n            = 1'b0;
      req_valid          = 1'b0;
      req_is_store       = 1'b0;
      req_size           = 2'd0;
      req_unsigned       = 1'b0;
      req_addr           = 64'd0;
      req_store_data     = 64'd0;
      req_rd             = 5'd0;
      main_waitrequest   = 1'b0;
      main_readdata      = 64'd0;
      main_readdatavalid = 1'b1;   // stray valid during reset must not matter

      // Reset state
      step();
      step();
      check("rst_resp_valid", resp_valid, 0);
      check("rst_read_write", {main_read, main_write}, 0);
      check("rst_address", main_address, 0);
      check("rst_byteenable", main_byteenable, 0);
      check("rst_writedata", main_writedata, 0);
      check("rst_resp_data", resp_data, 0);
      reset_n = 1'b1;
      step();
      main_readdatavalid = 1'b0;
      check("post_rst_ready", req_ready, 1);
      check("post_rst_no_resp", resp_valid, 0);

      // Byte loads, signed and unsigned, plus a signed word and an unsigned half
      run_load("lb", 2'd0, 1'b0, 64'h1003, 5'd5, 64'h0000_0000_8000_0000, 8'h08, 64'hFFFF_FFFF_FFFF_FF80);
      run_load("lbu", 2'd0, 1'b1, 64'h1003, 5'd6, 64'h0000_0000_8000_0000, 8'h08, 64'h0000_0000_0000_0080);
      run_load("lw", 2'd2, 1'b0, 64'h7004, 5'd9, 64'h8765_4321_0000_0000, 8'hF0, 64'hFFFF_FFFF_8765_4321);
      run_load("lhu", 2'd1, 1'b1, 64'h7006, 5'd10, 64'hBEEF_0000_0000_0000, 8'hC0, 64'h0000_0000_0000_BEEF);
      run_load("ld", 2'd3, 1'b1, 64'h7008, 5'd11, 64'hF000_0000_0000_0001, 8'hFF, 64'hF000_0000_0000_0001);

      // Store word with three stall cycles: write held four cycles
      main_waitrequest = 1'b1;
      set_req(1'b1, 2'd2, 1'b0, 64'h2004, 64'h0000_0000_DEAD_BEEF, 5'd7);
      step();
      req_valid = 1'b0;
      check("sw_write_c1", main_write, 1);
      check("sw_read_c1", main_read, 0);
      check("sw_addr", main_address, 32'h2000);
      check("sw_be", main_byteenable, 8'hF0);
      check("sw_wdata_hi", main_writedata[63:32], 32'hDEAD_BEEF);
      step();
      check("sw_write_c2", main_write, 1);
      step();
      check("sw_write_c3", main_write, 1);
      check("sw_no_early_resp", resp_valid, 0);
      step();
      main_waitrequest = 1'b0;
      check("sw_write_c4", main_write, 1);
      check("sw_be_held", main_byteenable, 8'hF0);
      check("sw_wdata_held", main_writedata, 64'hDEAD_BEEF_0000_0000);
      step();
      check("sw_write_drop", main_write, 0);
      check("sw_resp_valid", resp_valid, 1);
      check("sw_resp_data", resp_data, 0);
      check("sw_resp_rd", resp_rd, 7);
      step();
      check("sw_resp_pulse", resp_valid, 0);

      // Misaligned accesses never reach the bus
      run_misaligned("ld_mis", 2'd3, 64'h3004, 5'd12);
      run_misaligned("lh_mis", 2'd1, 64'h3001, 5'd13);

      // Watchdog: load with no readdatavalid, expiry after 8 counted cycles
      set_req(1'b0, 2'd3, 1'b0, 64'h4000, 64'd0, 5'd14);
      step();
      req_valid = 1'b0;
      check("to_read", main_read, 1);
      for (int i = 0; i < 7; i++) begin
         step();
         check($sformatf("to_wait_%0d", i), resp_valid, 0);
      end
      step();
      check("to_resp_valid", resp_valid, 1);
      check("to_bus_error", resp_bus_error, 1);
      check("to_resp_data", resp_data, 0);
      check("to_resp_rd", resp_rd, 14);
      check("to_read_low", main_read, 0);
      step();
      main_readdatavalid = 1'b1;
      main_readdata      = 64'h1234;
      check("to_ready", req_ready, 1);
      step();
      main_readdatavalid = 1'b0;
      check("late_rdv_ignored", resp_valid, 0);
      step();
      check("late_rdv_ignored2", resp_valid, 0);
      check("late_ready", req_ready, 1);

      // Reset during WAIT_DATA abandons the access
      set_req(1'b0, 2'd3, 1'b0, 64'h5000, 64'd0, 5'd15);
      step();
      req_valid = 1'b0;
      step();
      check("rw_read_drop", main_read, 0);
      reset_n = 1'b0;
      step();
      check("rw_in_reset_resp", resp_valid, 0);
      check("rw_in_reset_read", main_read, 0);
      reset_n            = 1'b1;
      main_readdatavalid = 1'b1;
      main_readdata      = 64'hAAAA;
      step();
      main_readdatavalid = 1'b0;
      check("rw_ready", req_ready, 1);
      check("rw_no_resp", resp_valid, 0);
      step();
      check("rw_no_resp2", resp_valid, 0);

      // Back-to-back LD then SD: SD waits until req_ready is high again
      set_req(1'b0, 2'd3, 1'b0, 64'h5008, 64'd0, 5'd3);
      step();
      set_req(1'b1, 2'd3, 1'b0, 64'h6000, 64'h0123_4567_89AB_CDEF, 5'd4);
      check("b2b_ld_read", main_read, 1);
      check("b2b_busy", req_ready, 0);
      step();
      main_readdatavalid = 1'b1;
      main_readdata      = 64'h1122_3344_5566_7788;
      check("b2b_sd_held_off", main_write, 0);
      step();
      main_readdatavalid = 1'b0;
      check("b2b_ld_resp", resp_valid, 1);
      check("b2b_ld_data", resp_data, 64'h1122_3344_5566_7788);
      check("b2b_ld_rd", resp_rd, 3);
      check("b2b_still_busy", req_ready, 0);
      step();
      check("b2b_ready", req_ready, 1);
      check("b2b_no_write_yet", main_write, 0);
      step();
      req_valid = 1'b0;
      check("b2b_sd_write", main_write, 1);
      check("b2b_sd_be", main_byteenable, 8'hFF);
      check("b2b_sd_wdata", main_writedata, 64'h0123_4567_89AB_CDEF);
      check("b2b_sd_addr", main_address, 32'h6000);
      step();
      check("b2b_sd_resp", resp_valid, 1);
      check("b2b_sd_rd", resp_rd, 4);
      check("b2b_sd_data", resp_data, 0);
      step();
      check("b2b_sd_pulse", resp_valid, 0);
      check("b2b_idle_write", main_write, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
